soc_bus_arb: RTL and testbench

SOC_BUS_ARB -- requirements
Module: soc_bus_arb

---
 rtl/chip_bus_pkg.sv | 19 +
 rtl/soc_rr_arb.sv | 27 ++
 rtl/soc_bus_arb.sv | 162 ++++++++++++++++
 tb/tb_soc_bus_arb.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/chip_bus_pkg.sv
// Shared bus definitions: arbiter FSM encoding, region decode width,
// unmapped-read fill pattern and access size encodings.
package chip_bus_pkg;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  typedef enum logic [2:0] {
    SZ_BYTE = 3'd0,
    SZ_HALF = 3'd1,
    SZ_WORD = 3'd2
  } size_t;

  localparam int          REGION_W = 4;
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/soc_rr_arb.sv
// Round-robin selector: search starts one past the last grant and wraps,
// first requester found wins. Output is one-hot (or zero when idle).
module soc_rr_arb #(
  parameter  int NUM_MASTERS = 2,
  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PW-1:0]          last,
  output logic [NUM_MASTERS-1:0] gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      idx = (int'(last) + off) % NUM_MASTERS;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/soc_bus_arb.sv
// Multi-master to multi-slave bus arbiter with round-robin grant, bounded
// bus locking and one-cycle read return. Define SOC_BUS_ARB_ERR_EN for error reporting.
module soc_bus_arb
  import chip_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 8,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int LOCK_MAX    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]        m_rd_i,
  input  logic [NUM_MASTERS-1:0]        m_we_i,
  input  logic [NUM_MASTERS*3-1:0]      m_size_i,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
  input  logic [NUM_MASTERS-1:0]        m_lock_i,
  output logic [NUM_MASTERS-1:0]        m_ready_o,
  output logic [NUM_MASTERS-1:0]        m_rvalid_o,
  output logic [DATA_W-1:0]             m_rdata_o,
  output logic [NUM_MASTERS-1:0]        m_err_o,
  output logic [NUM_SLAVES-1:0]         s_rd_o,
  output logic [NUM_SLAVES-1:0]         s_we_o,
  input  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i,
  output logic [ADDR_W-1:0]             s_addr_o,
  output logic [2:0]                    s_size_o,
  output logic [DATA_W-1:0]             s_wdata_o
);

  localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_t             state_q, state_d;
  logic [PW-1:0]          last_q, owner_q, owner_d, gidx;
  logic [CW-1:0]          lock_cnt_q, lock_cnt_d;
  logic [NUM_MASTERS-1:0] req, arb_req, gnt;
  logic                   any_gnt, g_rd, g_we, mapped, lock_tmo;
  logic [REGION_W-1:0]    sidx;
  logic [DATA_W-1:0]      rd_sel;
  logic [NUM_MASTERS-1:0] rvalid_q;
  logic [DATA_W-1:0]      rdata_q;

  // While locked, only the owner is presented to the selector.
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_req
    assign req[i]     = m_rd_i[i] | m_we_i[i];
    assign arb_req[i] = req[i] & ((state_q != LOCKED) || (owner_q == PW'(i)));
  end

  soc_rr_arb #(.NUM_MASTERS(NUM_MASTERS)) u_rr (
    .req  (arb_req),
    .last (last_q),
    .gnt  (gnt)
  );

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (gnt[i]) gidx = PW'(i);
  end

  assign any_gnt   = rst_n_i & (|gnt);
  assign m_ready_o = gnt & {NUM_MASTERS{rst_n_i}};
  assign s_addr_o  = m_addr_i[gidx*ADDR_W +: ADDR_W];
  assign s_size_o  = m_size_i[gidx*3 +: 3];
  assign s_wdata_o = m_wdata_i[gidx*DATA_W +: DATA_W];
  assign g_we      = m_we_i[gidx];
  assign g_rd      = m_rd_i[gidx] & ~g_we;
  assign sidx      = s_addr_o[ADDR_W-1 -: REGION_W];
  assign mapped    = int'(sidx) < NUM_SLAVES;

  always_comb begin
    s_rd_o = '0;
    s_we_o = '0;
    rd_sel = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (int'(sidx) == j) begin
        s_rd_o[j] = any_gnt & g_rd;
        s_we_o[j] = any_gnt & g_we;
        rd_sel    = s_data_i[j*DATA_W +: DATA_W];
      end
    end
  end

  assign lock_tmo = (state_q == LOCKED) && m_lock_i[owner_q] &&
                    (lock_cnt_q == CW'(LOCK_MAX - 1));

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ARB: begin
        if (any_gnt && m_lock_i[gidx]) begin
          state_d    = LOCKED;
          owner_d    = gidx;
          lock_cnt_d = '0;
        end
      end
      LOCKED: begin
        lock_cnt_d = lock_cnt_q + 1'b1;
        if (!m_lock_i[owner_q] || lock_tmo) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ARB;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      last_q     <= PW'(NUM_MASTERS - 1);
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      if (any_gnt) last_q <= gidx;
    end
  end

  // Reads never stall: each accepted read returns exactly one cycle later.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= '0;
      if (any_gnt && g_rd) begin
        rvalid_q[gidx] <= 1'b1;
`ifdef SOC_BUS_ARB_ERR_EN
        rdata_q <= mapped ? rd_sel : DATA_W'(ERR_DATA);
`else
        rdata_q <= mapped ? rd_sel : '0;
`endif
      end
    end
  end

  assign m_rvalid_o = rvalid_q;
  assign m_rdata_o  = rdata_q;

`ifdef SOC_BUS_ARB_ERR_EN
  logic [NUM_MASTERS-1:0] err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= '0;
    end else begin
      err_q <= '0;
      if (any_gnt && !mapped) err_q[gidx]    <= 1'b1;
      if (lock_tmo)           err_q[owner_q] <= 1'b1;
    end
  end

  assign m_err_o = err_q;
`else
  assign m_err_o = '0;
`endif

endmodule

// File: tb/tb_soc_bus_arb.sv
// Directed bench for soc_bus_arb; read returns are checked against a
// scoreboard queue filled when each read grant is observed.
module tb_soc_bus_arb;
  localparam int NM = 2, NS = 8, AW = 32, DW = 32;
`ifdef SOC_BUS_ARB_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic            clk = 1'b0, rst_n = 1'b0;
  logic [NM*AW-1:0] m_addr;
  logic [NM-1:0]    m_rd, m_we, m_lock, m_ready, m_rvalid, m_err;
  logic [NM*3-1:0]  m_size;
  logic [NM*DW-1:0] m_wdata;
  logic [DW-1:0]    m_rdata, s_wdata;
  logic [NS-1:0]    s_rd, s_we;
  logic [NS*DW-1:0] s_data;
  logic [AW-1:0]    s_addr;
  logic [2:0]       s_size;

  typedef struct {
    logic [NM-1:0] who;
    logic [DW-1:0] data;
  } rd_exp_t;

  rd_exp_t sb[$];
  int ntest = 0, nfail = 0;

  soc_bus_arb dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m_addr_i(m_addr), .m_rd_i(m_rd), .m_we_i(m_we), .m_size_i(m_size),
    .m_wdata_i(m_wdata), .m_lock_i(m_lock), .m_ready_o(m_ready),
    .m_rvalid_o(m_rvalid), .m_rdata_o(m_rdata), .m_err_o(m_err),
    .s_rd_o(s_rd), .s_we_o(s_we), .s_data_i(s_data), .s_addr_o(s_addr),
    .s_size_o(s_size), .s_wdata_o(s_wdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] sdat(int j);
    return 32'h5A5A_0000 + j * 32'h0101;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    ntest++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(logic [NM-1:0] who, logic [DW-1:0] data);
    rd_exp_t e;
    e.who  = who;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic setm(int i, logic rd, logic we, logic lk, logic [AW-1:0] a,
                      logic [2:0] sz, logic [DW-1:0] wd);
    m_rd[i] = rd;  m_we[i] = we;  m_lock[i] = lk;
    m_addr[i*AW +: AW] = a;  m_size[i*3 +: 3] = sz;  m_wdata[i*DW +: DW] = wd;
  endtask

  task automatic clr();
    setm(0, 0, 0, 0, '0, '0, '0);
    setm(1, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Every cycle: pop the read expected now, or insist no rvalid appears.
  always @(posedge clk) begin
    rd_exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("rvalid", 64'(m_rvalid), 64'(e.who));
      check("rdata", 64'(m_rdata), 64'(e.data));
    end else if (m_rvalid !== '0) begin
      check("spurious_rvalid", 64'(m_rvalid), 64'd0);
    end
  end

  initial begin
    logic [NM-1:0] exp_gnt;
    for (int j = 0; j < NS; j++) s_data[j*DW +: DW] = sdat(j);
    clr();
    rst_n = 1'b0;
    repeat (2) next();

    // Requests during reset are masked.
    setm(0, 1, 0, 0, 32'h1000_0000, 3'd2, '0);
    #4;
    check("rst_ready", 64'(m_ready), 64'd0);
    check("rst_srd", 64'(s_rd), 64'd0);
    check("rst_rvalid", 64'(m_rvalid), 64'd0);
    check("rst_rdata", 64'(m_rdata), 64'd0);
    check("rst_err", 64'(m_err), 64'd0);
    clr();
    next();
    rst_n = 1'b1;

    // Round robin between two continuous readers of slave 1.
    setm(0, 1, 0, 0, 32'h1000_0000, 3'd2, '0);
    setm(1, 1, 0, 0, 32'h1000_0010, 3'd1, '0);
    for (int k = 0; k < 4; k++) begin
      #4;
      exp_gnt = (k % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_ready", 64'(m_ready), 64'(exp_gnt));
      check("rr_srd", 64'(s_rd), 64'h02);
      check("rr_addr", 64'(s_addr), (k % 2 == 0) ? 64'h1000_0000 : 64'h1000_0010);
      check("rr_size", 64'(s_size), (k % 2 == 0) ? 64'd2 : 64'd1);
      push(exp_gnt, sdat(1));
      next();
    end
    clr();

    // Read and write together: write wins, no read return.
    setm(1, 1, 1, 0, 32'h3000_0008, 3'd2, 32'hCAFE_F00D);
    #4;
    check("wr_ready", 64'(m_ready), 64'h2);
    check("wr_swe", 64'(s_we), 64'h08);
    check("wr_srd", 64'(s_rd), 64'h00);
    check("wr_wdata", 64'(s_wdata), 64'hCAFE_F00D);
    next();
    clr();

    // Locked read then write by m0 while m1 keeps requesting.
    setm(0, 1, 0, 1, 32'h2000_0004, 3'd0, '0);
    setm(1, 1, 0, 0, 32'h1000_0000, 3'd2, '0);
    #4;
    check("lk_rd_ready", 64'(m_ready), 64'h1);
    check("lk_rd_srd", 64'(s_rd), 64'h04);
    push(2'b01, sdat(2));
    next();
    setm(0, 0, 1, 1, 32'h2000_0004, 3'd0, 32'h1234_5678);
    #4;
    check("lk_wr_ready", 64'(m_ready), 64'h1);
    check("lk_wr_swe", 64'(s_we), 64'h04);
    next();
    setm(0, 0, 0, 0, '0, '0, '0);
    #4;
    check("lk_drop_ready", 64'(m_ready), 64'h0);
    next();
    #4;
    check("lk_after_ready", 64'(m_ready), 64'h2);
    push(2'b10, sdat(1));
    next();
    clr();

    // Lock timeout: m0 keeps the lock, loses the bus after LOCK_MAX locked cycles.
    setm(0, 1, 0, 1, 32'h3000_0000, 3'd2, '0);
    setm(1, 1, 0, 0, 32'h1000_0000, 3'd2, '0);
    for (int c = 0; c < 18; c++) begin
      #4;
      exp_gnt = (c < 17) ? 2'b01 : 2'b10;
      check("tmo_ready", 64'(m_ready), 64'(exp_gnt));
      check("tmo_err", 64'(m_err), (ERR && c == 17) ? 64'h1 : 64'h0);
      push(exp_gnt, (c < 17) ? sdat(3) : sdat(1));
      next();
    end
    clr();
    #4;
    check("tmo_err_clr", 64'(m_err), 64'h0);
    next();

    // Unmapped read to region 9.
    setm(0, 1, 0, 0, 32'h9000_0000, 3'd2, '0);
    #4;
    check("um_ready", 64'(m_ready), 64'h1);
    check("um_srd", 64'(s_rd), 64'h0);
    check("um_swe", 64'(s_we), 64'h0);
    push(2'b01, ERR ? 32'hDEAD_BEEF : 32'h0);
    next();
    clr();
    #4;
    check("um_err", 64'(m_err), ERR ? 64'h1 : 64'h0);
    next();
    #4;
    check("rdata_hold", 64'(m_rdata), ERR ? 64'hDEAD_BEEF : 64'h0);
    next();

    // Reset lands on a granted read before its return edge.
    setm(1, 1, 0, 0, 32'h1000_0000, 3'd2, '0);
    #4;
    check("rs_gnt", 64'(m_ready), 64'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("rs_mask", 64'(m_ready), 64'h0);
    check("rs_mask_srd", 64'(s_rd), 64'h0);
    next();
    clr();
    next();
    check("rs_rvalid", 64'(m_rvalid), 64'h0);
    check("rs_rdata", 64'(m_rdata), 64'h0);
    rst_n = 1'b1;
    setm(0, 1, 0, 0, 32'h1000_0000, 3'd2, '0);
    setm(1, 1, 0, 0, 32'h1000_0000, 3'd2, '0);
    #4;
    check("rs_prio", 64'(m_ready), 64'h1);
    push(2'b01, sdat(1));
    next();
    clr();
    repeat (3) next();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
